// File: rtl/exmem_pkg.sv
// Shared types and constants for the execute-to-memory pipeline register stage.
package exmem_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  // One bit per opcode: ADD, SUB and SLT are the only ops that drive a meaningful overflow flag
  localparam logic [15:0] OVFL_OPS = 16'h008C;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Flag/control portion of a held entry; data fields are packed alongside it in the top
  typedef struct packed {
    logic zero;
    logic neg;
    logic ovfl;
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
  } exmem_flags_t;

  function automatic logic ovfl_capable(input logic [3:0] op);
    return OVFL_OPS[op];
  endfunction

endpackage

// File: rtl/exmem_skid_buf.sv
// One pipeline entry: a payload register with its valid bit; load wins over drop.
module exmem_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  logic         vld_d, vld_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (drop) vld_d = 1'b0;
    if (load) begin
      vld_d  = 1'b1;
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld = vld_q;
  assign q   = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, branch redirect and sticky overflow.
// Define EXMEM_SKID_EN to add a skid entry so in_ready comes straight from a flop.
module ex_mem_stage import exmem_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int RAW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              alu_ovfl,
  input  logic [3:0]        alu_op,
  input  logic              is_branch,
  input  logic [DATA_W-1:0] br_target,
  input  logic [DATA_W-1:0] st_data,
  input  logic [RAW-1:0]    dst,
  input  logic              reg_wr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              flush,
  input  logic              ovfl_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_st_data,
  output logic [RAW-1:0]    out_dst,
  output logic              out_reg_wr,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_ovfl,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_pc,
  output logic              ovfl_sticky
);

  localparam int PL_W = 2 * DATA_W + RAW + $bits(exmem_flags_t);

  exmem_flags_t      in_fl, out_fl;
  logic [PL_W-1:0]   in_pl, main_d, main_q;
  logic              acc, pop, main_load, main_drop, main_vld;
  state_e            cur_state;
  logic              br_taken_d, br_taken_q, ovfl_sticky_d, ovfl_sticky_q;
  logic [DATA_W-1:0] br_pc_d, br_pc_q;

  // Branches never write back or touch memory, so their control bits are cleared on entry
  always_comb begin
    in_fl.zero   = alu_zero;
    in_fl.neg    = alu_neg;
    in_fl.ovfl   = alu_ovfl & ovfl_capable(alu_op);
    in_fl.reg_wr = reg_wr & ~is_branch;
    in_fl.mem_rd = mem_rd & ~is_branch;
    in_fl.mem_wr = mem_wr & ~is_branch;
  end

  assign in_pl = {alu_r, st_data, dst, in_fl};
  assign pop   = main_vld & out_ready;
  assign acc   = in_valid & in_ready & ~flush;

  // The FSM state lives in the buffers' valid flops and is decoded here
`ifdef EXMEM_SKID_EN
  logic            skid_load, skid_drop, skid_vld, main_sel_skid;
  logic            in_ready_d, in_ready_q;
  logic [PL_W-1:0] skid_q;

  always_comb begin
    main_load     = 1'b0;
    main_drop     = 1'b0;
    skid_load     = 1'b0;
    skid_drop     = 1'b0;
    main_sel_skid = 1'b0;
    cur_state     = skid_vld ? ST_SKID : (main_vld ? ST_FULL : ST_EMPTY);
    if (flush) begin
      main_drop = 1'b1;
      skid_drop = 1'b1;
    end else begin
      case (cur_state)
        ST_EMPTY: main_load = acc;
        ST_FULL: begin
          if (acc && pop)  main_load = 1'b1;
          else if (acc)    skid_load = 1'b1;
          else if (pop)    main_drop = 1'b1;
        end
        ST_SKID: begin
          if (pop) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_drop     = 1'b1;
          end
        end
        default: ;
      endcase
    end
    in_ready_d = ~(skid_load | (skid_vld & ~skid_drop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready_q <= 1'b0;
    else        in_ready_q <= in_ready_d;
  end

  assign in_ready = in_ready_q;
  assign main_d   = main_sel_skid ? skid_q : in_pl;

  exmem_skid_buf #(.W(PL_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .drop  (skid_drop),
    .d     (in_pl),
    .vld   (skid_vld),
    .q     (skid_q)
  );
`else
  always_comb begin
    main_load = 1'b0;
    main_drop = 1'b0;
    cur_state = main_vld ? ST_FULL : ST_EMPTY;
    if (flush) begin
      main_drop = 1'b1;
    end else begin
      case (cur_state)
        ST_EMPTY: main_load = acc;
        ST_FULL: begin
          if (acc)      main_load = 1'b1;
          else if (pop) main_drop = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = rst_n & (~main_vld | out_ready);
  assign main_d   = in_pl;
`endif

  exmem_skid_buf #(.W(PL_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .drop  (main_drop),
    .d     (main_d),
    .vld   (main_vld),
    .q     (main_q)
  );

  // Redirect is tied to the accept itself, so a flushed branch never redirects
  always_comb begin
    br_taken_d    = acc & is_branch & alu_zero;
    br_pc_d       = br_taken_d ? br_target : br_pc_q;
    ovfl_sticky_d = ovfl_sticky_q;
    if (ovfl_clr)           ovfl_sticky_d = 1'b0;
    if (acc && in_fl.ovfl)  ovfl_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_q    <= 1'b0;
      br_pc_q       <= '0;
      ovfl_sticky_q <= 1'b0;
    end else begin
      br_taken_q    <= br_taken_d;
      br_pc_q       <= br_pc_d;
      ovfl_sticky_q <= ovfl_sticky_d;
    end
  end

  assign {out_r, out_st_data, out_dst, out_fl} = main_q;
  assign out_valid   = main_vld;
  assign out_zero    = out_fl.zero;
  assign out_neg     = out_fl.neg;
  assign out_ovfl    = out_fl.ovfl;
  assign out_reg_wr  = out_fl.reg_wr;
  assign out_mem_rd  = out_fl.mem_rd;
  assign out_mem_wr  = out_fl.mem_wr;
  assign br_taken    = br_taken_q;
  assign br_pc       = br_pc_q;
  assign ovfl_sticky = ovfl_sticky_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the driver queues expected entries, a negedge monitor checks them.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready;
  logic [15:0] alu_r;
  logic        alu_zero, alu_neg, alu_ovfl;
  logic [3:0]  alu_op;
  logic        is_branch;
  logic [15:0] br_target, st_data;
  logic [3:0]  dst;
  logic        reg_wr, mem_rd, mem_wr, flush, ovfl_clr;
  logic        out_valid, out_ready;
  logic [15:0] out_r, out_st_data;
  logic [3:0]  out_dst;
  logic        out_reg_wr, out_mem_rd, out_mem_wr, out_zero, out_neg, out_ovfl;
  logic        br_taken;
  logic [15:0] br_pc;
  logic        ovfl_sticky;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(16), .RAW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovfl(alu_ovfl),
    .alu_op(alu_op), .is_branch(is_branch), .br_target(br_target), .st_data(st_data),
    .dst(dst), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .flush(flush),
    .ovfl_clr(ovfl_clr), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_st_data(out_st_data), .out_dst(out_dst), .out_reg_wr(out_reg_wr),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_zero(out_zero),
    .out_neg(out_neg), .out_ovfl(out_ovfl), .br_taken(br_taken), .br_pc(br_pc),
    .ovfl_sticky(ovfl_sticky)
  );

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] st;
    logic [3:0]  dst;
    logic        zero, neg, ovfl, rw, mr, mw;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          acc_cnt = 0;
  logic        exp_br = 1'b0;
  logic [15:0] exp_br_pc = 16'h0;

`ifdef EXMEM_SKID_EN
  localparam int STALL_ACCEPTS = 2;
`else
  localparam int STALL_ACCEPTS = 1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      check("br_taken", 32'(br_taken), 32'(exp_br));
      if (exp_br) check("br_pc", 32'(br_pc), 32'(exp_br_pc));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(out_r), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_r",       32'(out_r),       32'(e.r));
          check("out_st_data", 32'(out_st_data), 32'(e.st));
          check("out_dst",     32'(out_dst),     32'(e.dst));
          check("out_zero",    32'(out_zero),    32'(e.zero));
          check("out_neg",     32'(out_neg),     32'(e.neg));
          check("out_ovfl",    32'(out_ovfl),    32'(e.ovfl));
          check("out_reg_wr",  32'(out_reg_wr),  32'(e.rw));
          check("out_mem_rd",  32'(out_mem_rd),  32'(e.mr));
          check("out_mem_wr",  32'(out_mem_wr),  32'(e.mw));
        end
      end
    end
  end

  task automatic set_idle;
    in_valid  = 1'b0;
    is_branch = 1'b0;
    flush     = 1'b0;
    ovfl_clr  = 1'b0;
  endtask

  // Present one entry; st_data is ~r and dst is r[3:0], expected flags are supplied by hand
  task automatic present(input logic [3:0] op, input logic [15:0] r, input logic z, input logic ov,
                         input logic br, input logic [15:0] tgt, input logic rw, input logic mr,
                         input logic mw, input logic e_ov, input logic e_rw, input logic e_mr,
                         input logic e_mw);
    alu_op    = op;
    alu_r     = r;
    alu_zero  = z;
    alu_neg   = r[15];
    alu_ovfl  = ov;
    is_branch = br;
    br_target = tgt;
    st_data   = ~r;
    dst       = r[3:0];
    reg_wr    = rw;
    mem_rd    = mr;
    mem_wr    = mw;
    in_valid  = 1'b1;
    cur_exp   = '{r: r, st: ~r, dst: r[3:0], zero: z, neg: r[15], ovfl: e_ov,
                  rw: e_rw, mr: e_mr, mw: e_mw};
  endtask

  // One clock: bookkeeping after the monitor's negedge sample, returns 1 time unit past posedge
  task automatic tick;
    logic acc, nb;
    @(negedge clk);
    #1;
    acc = in_valid && in_ready && !flush;
    if (flush) sb.delete();
    if (acc) begin
      sb.push_back(cur_exp);
      acc_cnt++;
    end
    nb = acc && is_branch && alu_zero;
    @(posedge clk);
    #1;
    exp_br = nb;
    if (nb) exp_br_pc = br_target;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    alu_op = 4'd0; alu_r = 16'h0; alu_zero = 1'b0; alu_neg = 1'b0; alu_ovfl = 1'b0;
    br_target = 16'h0; st_data = 16'h0; dst = 4'h0;
    reg_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; out_ready = 1'b1;
    cur_exp = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_sticky",    32'(ovfl_sticky), 32'd0);
    check("rst_br_taken",  32'(br_taken),  32'd0);
    check("rst_out_r",     32'(out_r),     32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // ADD overflow: one-cycle latency, flag and sticky set
    present(4'd2, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("add_out_valid", 32'(out_valid), 32'd1);
    check("add_out_r",     32'(out_r),     32'h8000);
    check("add_out_ovfl",  32'(out_ovfl),  32'd1);
    check("add_sticky",    32'(ovfl_sticky), 32'd1);
    set_idle(); tick();

    // AND with a stale overflow flag
    present(4'd0, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("stale_out_ovfl", 32'(out_ovfl), 32'd0);
    check("stale_sticky",   32'(ovfl_sticky), 32'd1);
    set_idle(); ovfl_clr = 1'b1; tick();
    check("clr_sticky", 32'(ovfl_sticky), 32'd0);
    set_idle();
    present(4'd0, 16'h00F0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("stale2_sticky", 32'(ovfl_sticky), 32'd0);

    // Taken branch: redirect pulse, write-back and memory controls suppressed
    set_idle();
    present(4'd3, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("br_pulse",   32'(br_taken),   32'd1);
    check("br_pc_val",  32'(br_pc),      32'h0040);
    check("br_reg_wr",  32'(out_reg_wr), 32'd0);
    set_idle(); tick();
    check("br_pulse_end", 32'(br_taken), 32'd0);
    present(4'd3, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0080, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("br_not_taken", 32'(br_taken), 32'd0);
    set_idle(); tick();

    // Back-pressure for 3 cycles with the source offering a new entry each cycle
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      present(4'd1, 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check("stall_out_r",     32'(out_r),     32'hA000);
      check("stall_out_valid", 32'(out_valid), 32'd1);
    end
    check("stall_accepts",  32'(acc_cnt),  32'(STALL_ACCEPTS));
    check("stall_in_ready", 32'(in_ready), 32'd0);
    set_idle(); out_ready = 1'b1;
    repeat (3) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Flush wins over an accepting branch
    present(4'd3, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_br",    32'(br_taken),  32'd0);
    set_idle(); out_ready = 1'b0;
    present(4'd4, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_idle(); flush = 1'b1;
    tick();
    check("flush_held_valid", 32'(out_valid), 32'd0);
    set_idle(); out_ready = 1'b1;
    tick();

    // Back-to-back entries under continuous ready
    for (int i = 0; i < 4; i++) begin
      present(4'd2, 16'h1000 * 16'(i + 1), 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1,
              1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_r",     32'(out_r),     32'h1000 * 32'(i + 1));
    end
    set_idle(); tick(); tick();

    // Clear and set of the sticky flag in the same cycle
    present(4'd3, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    ovfl_clr = 1'b1;
    tick();
    check("setclr_sticky", 32'(ovfl_sticky), 32'd1);
    set_idle(); tick();

    // Asynchronous reset while holding an entry
    out_ready = 1'b0;
    present(4'd5, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_idle();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(out_valid),   32'd0);
    check("arst_out_r",  32'(out_r),       32'd0);
    check("arst_sticky", 32'(ovfl_sticky), 32'd0);
    check("arst_ready",  32'(in_ready),    32'd0);
    sb.delete();
    exp_br = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, datapath width; RAW, default 4, destination-register address width.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute result present
- in_ready  out  1  stage can accept
- alu_r  in  DATA_W  ALU result
- alu_zero  in  1  ALU zero flag, already BIEQ-polarised
- alu_neg  in  1  ALU negative flag
- alu_ovfl  in  1  ALU overflow flag
- alu_op  in  4  ALU opcode used
- is_branch  in  1  instruction is a conditional branch
- br_target  in  DATA_W  branch destination PC
- st_data  in  DATA_W  store data
- dst  in  RAW  destination register
- reg_wr, mem_rd, mem_wr  in  1 each  control bits
- flush  in  1  discard all held entries
- ovfl_clr  in  1  clear sticky overflow
- out_valid  out  1  entry presented to memory stage
- out_ready  in  1  memory stage accepts
- out_r, out_st_data  out  DATA_W  registered result, store data
- out_dst  out  RAW; out_reg_wr, out_mem_rd, out_mem_wr  out  1 each
- out_zero, out_neg, out_ovfl  out  1 each  registered flags
- br_taken  out  1  one-cycle redirect pulse
- br_pc  out  DATA_W  redirect PC, valid with br_taken
- ovfl_sticky  out  1  sticky overflow status
REQ-003 Clocking SHALL be one clock domain on clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 Transfers SHALL occur: input on in_valid&&in_ready at the rising edge; output on out_valid&&out_ready at the rising edge.
REQ-005 Latency SHALL be one cycle from accept to out_valid, with no bubble under continuous out_ready=1 (throughput 1/cycle).
REQ-006 State machine SHALL be EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on accept; FULL->EMPTY on output without accept; FULL->FULL on simultaneous output and accept (new entry loads).
REQ-007 out_* payload SHALL be stable while out_valid=1 and out_ready=0.
REQ-008 out_ovfl SHALL be alu_ovfl masked to alu_op in {2,3,7}; all other opcodes SHALL register 0 (ALU ovfl is stale for them).
REQ-009 br_taken SHALL pulse for exactly one cycle, the cycle after accepting an entry with is_branch=1 and alu_zero=1; br_pc SHALL equal that entry's br_target; br_taken SHALL be 0 otherwise.
REQ-010 A branch entry SHALL force out_reg_wr, out_mem_rd, out_mem_wr to 0.
REQ-011 ovfl_sticky SHALL set on accept of an entry with masked overflow=1 and clear on ovfl_clr; simultaneous set and clear SHALL yield 1.
REQ-012 flush SHALL empty all entries at the next edge and suppress any accept in the same cycle (flush wins); br_taken from an entry accepted in the flush cycle SHALL NOT assert.
REQ-013 in_valid=0 in EMPTY SHALL leave payload registers unchanged.

Reset
REQ-014 rst_n=0 SHALL immediately force out_valid=0, br_taken=0, ovfl_sticky=0, all out_* payload and flags to 0, br_pc=0, state EMPTY; reset mid-transfer SHALL drop the entry.
REQ-015 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-016 Macro EXMEM_SKID_EN SHALL select the buffering mode.
- Defined: a second skid entry is added; in_ready SHALL be a register output (no combinational path from out_ready); states EMPTY/FULL/SKID; in_ready=0 only in SKID; order SHALL be preserved.
- Undefined: in_ready SHALL equal !out_valid || out_ready.
REQ-017 Latency SHALL be identical in both modes.

Structure
REQ-018 Shared package SHALL hold: ALU opcode constants (AND=0 ... SLT=7), the overflow-capable opcode set, state encodings, and a payload struct typedef.
REQ-019 Design SHALL use one sub-module, exmem_skid_buf (payload register plus valid), instantiated once, or twice under EXMEM_SKID_EN.

Verification
REQ-020 Bench SHALL cover:
- Op 2, alu_r=16'h8000, ovfl=1, out_ready=1 -> next cycle out_valid=1, out_r=8000, out_ovfl=1, ovfl_sticky=1.
- Op 0 with alu_ovfl=1 (stale) -> out_ovfl=0, ovfl_sticky unchanged.
- is_branch=1, alu_zero=1, br_target=16'h0040 -> single-cycle br_taken=1, br_pc=0040, out_reg_wr=0.
- out_ready=0 for 3 cycles with in_valid=1 -> payload held stable, no entry lost or duplicated; skid mode accepts exactly one extra entry.
- flush together with in_valid=1 on a branch -> next cycle out_valid=0, br_taken=0.
- rst_n low while FULL -> out_valid=0 asynchronously; ovfl_clr and overflow in same cycle -> ovfl_sticky=1.
